// File: rtl/connection_block_unidir_nch.sv
// connection_block_unidir_nch
// Unidirectional connection block that serves NCLB CLBs. Single and double tracks
// are routed into the CLB inputs, and CLB outputs can replace individual track
// bits. Carries are chained from CLB 0 to CLB NCLB-1.
//
// Routing comes from a serial configuration chain. Config data is shifted in
// MSB-first on shift_in and leaves on shift_out. Each bit is taken in on a
// cycle where cen=1.
//
// Optional feature macro: CB_CFG_SHADOW_EN
//   defined   : the shift chain is a shadow register. The routing uses a
//               separate active copy. That copy loads only when set_in arrives
//               after exactly CFG_BITS shifted bits. Any other bit count sets
//               the sticky cfg_err flag instead.
//   undefined : the routing decodes directly from the shift chain. set_in is
//               ignored and cfg_err is tied to 0.
//
// Reset: rst is asynchronous and active-low.
module connection_block_unidir_nch #(
  parameter int WS     = 4,
  parameter int WD     = 8,
  parameter int NCLB   = 2,
  parameter int CLBIN  = 10,
  parameter int CLBOUT = 5,
  parameter int CARRY  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen,
  input  logic                     set_in,
  input  logic                     shift_in,
  output logic                     shift_out,
  output logic                     cfg_err,
  input  logic [WS-1:0]            single0_in,
  input  logic [WS-1:0]            single1_in,
  input  logic [WD-1:0]            double0_in,
  input  logic [WD-1:0]            double1_in,
  output logic [WS-1:0]            single0_out,
  output logic [WS-1:0]            single1_out,
  output logic [WD-1:0]            double0_out,
  output logic [WD-1:0]            double1_out,
  input  logic [NCLB*CLBOUT-1:0]   clb_output,
  input  logic [NCLB*CARRY-1:0]    clb_cout,
  output logic [NCLB*CLBIN-1:0]    clb_input,
  output logic [NCLB*CARRY-1:0]    clb_cin,
  input  logic [CARRY-1:0]         cin,
  output logic [CARRY-1:0]         cout
);

  localparam int T        = 2*WS + 2*WD;
  localparam int SELW_I   = (T > 1) ? $clog2(T) : 1;
  localparam int NO       = NCLB*CLBOUT;
  localparam int SELW_O   = (NO > 1) ? $clog2(NO) : 1;
  localparam int FW       = 1 + SELW_O;
  localparam int NPIN     = NCLB*CLBIN;
  localparam int OB       = NPIN*SELW_I;
  localparam int CFG_BITS = OB + T*FW;

  logic [T-1:0]        trk;
  logic [T-1:0]        trk_out;
  logic [CFG_BITS-1:0] shadow_q;
  logic [CFG_BITS-1:0] shadow_d;
  logic [CFG_BITS-1:0] cfg_img;

  // Track pool: single0_in[0] is index 0, double1_in is at the top.
  assign trk = {double1_in, double0_in, single1_in, single0_in};
  assign {double1_out, double0_out, single1_out, single0_out} = trk_out;

  // shift_out taps the shadow MSB directly, so it is a flop output.
  assign shift_out = shadow_q[CFG_BITS-1];

  // Next shadow value: shift one bit in at the LSB while cen is high.
  always_comb begin
    shadow_d = shadow_q;
    if (cen) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], shift_in};
    end
  end

  // Shadow register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

`ifdef CB_CFG_SHADOW_EN
  localparam int CNT_W = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [CFG_BITS-1:0] active_q;
  logic [CFG_BITS-1:0] active_d;
  logic                cfg_err_q;
  logic                cfg_err_d;

  // Bit counter and guarded commit. The commit decision uses the pre-edge
  // count, and it copies the pre-edge shadow even when a shift happens in the
  // same cycle. That shift is then the first bit of the next image.
  always_comb begin
    cnt_d     = cnt_q;
    active_d  = active_q;
    cfg_err_d = cfg_err_q;
    if (cen && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (set_in) begin
      if (cnt_q == CNT_FULL) begin
        active_d = shadow_q;
        cnt_d    = cen ? CNT_W'(1) : '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  // Counter, active image and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      active_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_img = active_q;
  assign cfg_err = cfg_err_q;
`else
  logic unused_set_in;

  assign unused_set_in = set_in;
  assign cfg_img       = shadow_q;
  assign cfg_err       = 1'b0;
`endif

  // Input muxes: each CLB pin selects one track. A select of T or above
  // drives the pin to 0.
  always_comb begin
    clb_input = '0;
    for (int p = 0; p < NPIN; p++) begin
      for (int t = 0; t < T; t++) begin
        if (int'(cfg_img[p*SELW_I +: SELW_I]) == t) begin
          clb_input[p] = trk[t];
        end
      end
    end
  end

  // Output muxes: each track has an enable bit (the field LSB) and a select
  // field above it. When the enable is 0, the track bit passes straight
  // through. When it is 1, the selected CLB output drives the track bit, or 0
  // if the select is out of range.
  always_comb begin
    trk_out = trk;
    for (int t = 0; t < T; t++) begin
      if (cfg_img[OB + t*FW]) begin
        trk_out[t] = 1'b0;
        for (int o = 0; o < NO; o++) begin
          if (int'(cfg_img[OB + t*FW + 1 +: SELW_O]) == o) begin
            trk_out[t] = clb_output[o];
          end
        end
      end
    end
  end

  // Carry chain: cin feeds CLB 0, and each later CLB takes its neighbour's carry out.
  always_comb begin
    clb_cin             = '0;
    clb_cin[0 +: CARRY] = cin;
    for (int k = 1; k < NCLB; k++) begin
      clb_cin[k*CARRY +: CARRY] = clb_cout[(k-1)*CARRY +: CARRY];
    end
  end

  assign cout = clb_cout[(NCLB-1)*CARRY +: CARRY];

endmodule

// File: tb/tb_connection_block_unidir_nch.sv
// Directed testbench for connection_block_unidir_nch at its default parameters.
// Follows the build: defining CB_CFG_SHADOW_EN selects the double-buffered checks.
module tb_connection_block_unidir_nch;

  localparam int CFG_BITS = 220;
  localparam int SELW_I   = 5;
  localparam int SELW_O   = 4;
  localparam int FW       = 5;
  localparam int OB       = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b0;
  logic        set_in = 1'b0;
  logic        shift_in = 1'b0;
  logic        shift_out;
  logic        cfg_err;
  logic [3:0]  single0_in = '0;
  logic [3:0]  single1_in = '0;
  logic [7:0]  double0_in = '0;
  logic [7:0]  double1_in = '0;
  logic [3:0]  single0_out;
  logic [3:0]  single1_out;
  logic [7:0]  double0_out;
  logic [7:0]  double1_out;
  logic [9:0]  clb_output = '0;
  logic [1:0]  clb_cout = '0;
  logic [19:0] clb_input;
  logic [1:0]  clb_cin;
  logic [0:0]  cin = '0;
  logic [0:0]  cout;

  int n_vec = 0;
  int n_err = 0;

  // Clock and DUT.
  always #5 clk = ~clk;

  connection_block_unidir_nch #(
    .WS(4), .WD(8), .NCLB(2), .CLBIN(10), .CLBOUT(5), .CARRY(1)
  ) dut (
    .clk(clk), .rst(rst), .cen(cen), .set_in(set_in), .shift_in(shift_in),
    .shift_out(shift_out), .cfg_err(cfg_err),
    .single0_in(single0_in), .single1_in(single1_in),
    .double0_in(double0_in), .double1_in(double1_in),
    .single0_out(single0_out), .single1_out(single1_out),
    .double0_out(double0_out), .double1_out(double1_out),
    .clb_output(clb_output), .clb_cout(clb_cout),
    .clb_input(clb_input), .clb_cin(clb_cin),
    .cin(cin), .cout(cout)
  );

  // Config image helpers.
  function automatic logic [CFG_BITS-1:0] set_pin(input logic [CFG_BITS-1:0] v,
                                                  input int p, input int sel);
    logic [CFG_BITS-1:0] r;
    r = v;
    r[p*SELW_I +: SELW_I] = SELW_I'(sel);
    return r;
  endfunction

  function automatic logic [CFG_BITS-1:0] set_trk(input logic [CFG_BITS-1:0] v,
                                                  input int t, input logic en,
                                                  input int sel);
    logic [CFG_BITS-1:0] r;
    r = v;
    r[OB + t*FW +: FW] = {SELW_O'(sel), en};
    return r;
  endfunction

  // Driver tasks.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; cen = 1'b0; set_in = 1'b0; shift_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive_trk(input logic [3:0] s0, input logic [3:0] s1,
                           input logic [7:0] d0, input logic [7:0] d1);
    single0_in = s0; single1_in = s1; double0_in = d0; double1_in = d1;
    #1;
  endtask

  task automatic shift_range(input logic [CFG_BITS-1:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      @(negedge clk);
      cen = 1'b1; shift_in = v[i];
    end
    @(negedge clk);
    cen = 1'b0; shift_in = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk);
    set_in = 1'b1;
    @(negedge clk);
    set_in = 1'b0;
    #1;
  endtask

  // Reset state: every pin takes single0_in[0] and all tracks pass through.
  task automatic test_reset();
    do_reset();
    drive_trk(4'b0001, 4'hA, 8'h5C, 8'h93);
    n_vec++;
    if (clb_input !== 20'hFFFFF) begin
      n_err++; $display("FAIL reset_clb_input got %h exp %h", clb_input, 20'hFFFFF);
    end
    n_vec++;
    if ({double1_out, double0_out, single1_out, single0_out} !== 24'h935CA1) begin
      n_err++; $display("FAIL reset_passthru got %h exp %h",
                        {double1_out, double0_out, single1_out, single0_out}, 24'h935CA1);
    end
    n_vec++;
    if (cfg_err !== 1'b0) begin
      n_err++; $display("FAIL reset_cfg_err got %b exp 0", cfg_err);
    end
    n_vec++;
    if (shift_out !== 1'b0) begin
      n_err++; $display("FAIL reset_shift_out got %b exp 0", shift_out);
    end
    drive_trk(4'b1110, 4'h0, 8'h00, 8'h00);
    n_vec++;
    if (clb_input !== 20'h00000) begin
      n_err++; $display("FAIL reset_clb_input0 got %h exp %h", clb_input, 20'h0);
    end
  endtask

  // Input mux: pin0 selects track 5, pin11 track 23, pin19 is out of range.
  task automatic test_input_mux();
    logic [CFG_BITS-1:0] img;
    img = '0;
    img = set_pin(img, 0, 5);
    img = set_pin(img, 11, 23);
    img = set_pin(img, 19, 30);
    do_reset();
    drive_trk(4'b0000, 4'b0010, 8'h00, 8'h80);
    shift_range(img, CFG_BITS-1, 0);
    #1;
`ifdef CB_CFG_SHADOW_EN
    n_vec++;
    if (clb_input !== 20'h00000) begin
      n_err++; $display("FAIL in_mux_precommit got %h exp %h", clb_input, 20'h0);
    end
    commit();
`endif
    n_vec++;
    if (clb_input !== 20'h00801) begin
      n_err++; $display("FAIL in_mux_p1 got %h exp %h", clb_input, 20'h00801);
    end
    drive_trk(4'b0001, 4'b0000, 8'h00, 8'h00);
    n_vec++;
    if (clb_input !== 20'h7F7FE) begin
      n_err++; $display("FAIL in_mux_p2 got %h exp %h", clb_input, 20'h7F7FE);
    end
    drive_trk(4'b0000, 4'b0010, 8'hA5, 8'h00);
    n_vec++;
    if ({double0_out, single1_out} !== 12'hA52) begin
      n_err++; $display("FAIL in_mux_passthru got %h exp %h", {double0_out, single1_out}, 12'hA52);
    end
  endtask

  // Output mux: track0 takes CLB1 output 2, track23 has an out-of-range select,
  // and track5 has a select programmed but its enable is off.
  task automatic test_output_mux();
    logic [CFG_BITS-1:0] img;
    img = '0;
    img = set_trk(img, 0, 1'b1, 7);
    img = set_trk(img, 23, 1'b1, 12);
    img = set_trk(img, 5, 1'b0, 3);
    do_reset();
    clb_output = 10'h080;
    drive_trk(4'b0000, 4'b0010, 8'h3C, 8'h80);
    shift_range(img, CFG_BITS-1, 0);
`ifdef CB_CFG_SHADOW_EN
    commit();
`endif
    #1;
    n_vec++;
    if ({double1_out, double0_out, single1_out, single0_out} !== 24'h003C21) begin
      n_err++; $display("FAIL out_mux_en got %h exp %h",
                        {double1_out, double0_out, single1_out, single0_out}, 24'h003C21);
    end
    clb_output = 10'h37F;
    #1;
    n_vec++;
    if (single0_out !== 4'b0000) begin
      n_err++; $display("FAIL out_mux_clb0 got %b exp 0000", single0_out);
    end
    clb_output = 10'h080;
    drive_trk(4'b1111, 4'b0010, 8'h3C, 8'h80);
    n_vec++;
    if (single0_out !== 4'b1111) begin
      n_err++; $display("FAIL out_mux_hi got %b exp 1111", single0_out);
    end
    clb_output = 10'h000;
    #1;
    n_vec++;
    if (single0_out !== 4'b1110) begin
      n_err++; $display("FAIL out_mux_lo got %b exp 1110", single0_out);
    end
    // Same select with the enable cleared: track 0 passes single0_in[0] through.
    img = set_trk('0, 0, 1'b0, 7);
    shift_range(img, CFG_BITS-1, 0);
`ifdef CB_CFG_SHADOW_EN
    commit();
`endif
    clb_output = 10'h080;
    drive_trk(4'b0001, 4'b0000, 8'h00, 8'h00);
    n_vec++;
    if (single0_out !== 4'b0001) begin
      n_err++; $display("FAIL out_mux_dis1 got %b exp 0001", single0_out);
    end
    drive_trk(4'b0000, 4'b0000, 8'h00, 8'h00);
    n_vec++;
    if (single0_out !== 4'b0000) begin
      n_err++; $display("FAIL out_mux_dis0 got %b exp 0000", single0_out);
    end
    clb_output = 10'h000;
  endtask

  // A lone 1 reaches shift_out exactly CFG_BITS edges after it is shifted in.
  task automatic test_shift_out();
    do_reset();
    for (int i = 0; i < 222; i++) begin
      @(negedge clk);
      if (i == 1 || i == 219 || i == 221) begin
        n_vec++;
        if (shift_out !== 1'b0) begin
          n_err++; $display("FAIL shift_out_%0d got %b exp 0", i, shift_out);
        end
      end
      if (i == 220) begin
        n_vec++;
        if (shift_out !== 1'b1) begin
          n_err++; $display("FAIL shift_out_%0d got %b exp 1", i, shift_out);
        end
      end
      cen = 1'b1;
      shift_in = (i == 0);
    end
    cen = 1'b0; shift_in = 1'b0;
  endtask

  // set_in after 219 bits does not commit, then after 220 bits it does.
  task automatic test_bad_count();
    logic [CFG_BITS-1:0] img;
    img = set_pin('0, 0, 5);
    img = set_pin(img, 11, 23);
    do_reset();
    drive_trk(4'b0000, 4'b0010, 8'h00, 8'h80);
    shift_range(img, CFG_BITS-1, 1);
    commit();
`ifdef CB_CFG_SHADOW_EN
    n_vec++;
    if (cfg_err !== 1'b1) begin
      n_err++; $display("FAIL bad_cnt_err got %b exp 1", cfg_err);
    end
    n_vec++;
    if (clb_input !== 20'h00000) begin
      n_err++; $display("FAIL bad_cnt_route got %h exp %h", clb_input, 20'h0);
    end
`else
    n_vec++;
    if (cfg_err !== 1'b0) begin
      n_err++; $display("FAIL bad_cnt_err got %b exp 0", cfg_err);
    end
`endif
    shift_range(img, 0, 0);
    commit();
    n_vec++;
    if (clb_input !== 20'h00801) begin
      n_err++; $display("FAIL good_cnt_route got %h exp %h", clb_input, 20'h00801);
    end
`ifdef CB_CFG_SHADOW_EN
    n_vec++;
    if (cfg_err !== 1'b1) begin
      n_err++; $display("FAIL err_sticky got %b exp 1", cfg_err);
    end
`else
    n_vec++;
    if (cfg_err !== 1'b0) begin
      n_err++; $display("FAIL err_tied got %b exp 0", cfg_err);
    end
`endif
  endtask

  // cen and set_in together at a full count, then reset mid-stream.
  task automatic test_back_to_back();
    logic [CFG_BITS-1:0] img_a;
    logic [CFG_BITS-1:0] img_b;
    img_a = set_pin('0, 0, 5);
    img_b = set_pin('0, 0, 1);
    do_reset();
    drive_trk(4'b0010, 4'b0000, 8'h00, 8'h00);
    shift_range(img_a, CFG_BITS-1, 0);
`ifdef CB_CFG_SHADOW_EN
    commit();
`endif
    shift_range(img_b, CFG_BITS-1, 0);
    @(negedge clk);
    cen = 1'b1; shift_in = 1'b0; set_in = 1'b1;
    @(negedge clk);
    cen = 1'b0; set_in = 1'b0;
    #1;
`ifdef CB_CFG_SHADOW_EN
    n_vec++;
    if (clb_input !== 20'h00001) begin
      n_err++; $display("FAIL b2b_commit got %h exp %h", clb_input, 20'h00001);
    end
    // One bit is already counted, so 219 more make a full image.
    shift_range('0, CFG_BITS-2, 0);
    commit();
    n_vec++;
    if (cfg_err !== 1'b0) begin
      n_err++; $display("FAIL b2b_cnt1 got %b exp 0", cfg_err);
    end
    n_vec++;
    if (clb_input !== 20'h00000) begin
      n_err++; $display("FAIL b2b_second got %h exp %h", clb_input, 20'h0);
    end
`else
    n_vec++;
    if (cfg_err !== 1'b0) begin
      n_err++; $display("FAIL b2b_err got %b exp 0", cfg_err);
    end
`endif
    // Reset mid-stream: the async reset clears routing before the next edge.
    shift_range(img_a, CFG_BITS-1, 0);
`ifdef CB_CFG_SHADOW_EN
    commit();
`endif
    drive_trk(4'b0001, 4'b0000, 8'h00, 8'h00);
    shift_range(img_a, CFG_BITS-1, CFG_BITS-50);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (clb_input !== 20'hFFFFF) begin
      n_err++; $display("FAIL midrst_route got %h exp %h", clb_input, 20'hFFFFF);
    end
    n_vec++;
    if ({shift_out, cfg_err} !== 2'b00) begin
      n_err++; $display("FAIL midrst_flags got %b exp 00", {shift_out, cfg_err});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Carry chain.
  task automatic test_carry();
    cin = 1'b1; clb_cout = 2'b00;
    #1;
    n_vec++;
    if ({clb_cin, cout} !== 3'b010) begin
      n_err++; $display("FAIL carry_a got %b exp 010", {clb_cin, cout});
    end
    clb_cout = 2'b10;
    #1;
    n_vec++;
    if ({clb_cin, cout} !== 3'b011) begin
      n_err++; $display("FAIL carry_b got %b exp 011", {clb_cin, cout});
    end
    cin = 1'b0; clb_cout = 2'b01;
    #1;
    n_vec++;
    if ({clb_cin, cout} !== 3'b100) begin
      n_err++; $display("FAIL carry_c got %b exp 100", {clb_cin, cout});
    end
  endtask

  // Sequence and report.
  initial begin
    test_reset();
    test_input_mux();
    test_output_mux();
    test_shift_out();
    test_bad_count();
    test_back_to_back();
    test_carry();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/connection_block_unidir_nch.md
# connection_block_unidir_nch

Parametrised, double-buffered unidirectional connection block for the fabric tile, generalising the fixed two-CLB block to `NCLB` CLBs per block. It routes single and double tracks into CLB inputs, drives CLB outputs onto tracks, and chains carries between CLBs. Routing is set by a bit-counted serial config chain with a shadow register and a guarded commit.

## Interface
- `WS`, 4, single-wire tracks per direction bundle
- `WD`, 8, double-wire tracks per direction bundle
- `NCLB`, 2, CLBs served (≥1)
- `CLBIN`, 10, inputs per CLB
- `CLBOUT`, 5, outputs per CLB
- `CARRY`, 1, carry width per CLB
- Derived values:
  - `T` = 2·WS + 2·WD
  - `SELW_I` = clog2(T)
  - `SELW_O` = clog2(NCLB·CLBOUT)
  - `CFG_BITS` = NCLB·CLBIN·SELW_I + T·(1+SELW_O), which is 220 at the defaults

Ports:
- `clk`  in  1  fabric clock
- `rst`  in  1  asynchronous reset, active-low
- `cen`  in  1  config shift enable
- `set_in`  in  1  commit request (shadow → active)
- `shift_in`  in  1  config serial in
- `shift_out`  out  1  config serial out, registered
- `cfg_err`  out  1  sticky: set_in arrived with a wrong bit count
- `single0_in`, `single1_in`  in  WS each  incoming singles
- `double0_in`, `double1_in`  in  WD each  incoming doubles
- `single0_out`, `single1_out`  out  WS each
- `double0_out`, `double1_out`  out  WD each
- `clb_output`  in  NCLB·CLBOUT  packed CLB outputs; CLB k at `[k·CLBOUT +: CLBOUT]`
- `clb_cout`  in  NCLB·CARRY  packed carries out
- `clb_input`  out  NCLB·CLBIN  packed CLB inputs
- `clb_cin`  out  NCLB·CARRY  packed carries in
- `cin`  in  CARRY  carry into CLB 0
- `cout`  out  CARRY  carry out of CLB NCLB-1

## Operation
- Track pool `trk[T-1:0]` = {double1_in, double0_in, single1_in, single0_in}. `single0_in[0]` is index 0.
- Input muxes: `clb_input[k·CLBIN+j]` = `trk[sel]`, where sel = `active[(k·CLBIN+j)·SELW_I +: SELW_I]`. If sel ≥ T, the input is 0.
- Output muxes: OB = NCLB·CLBIN·SELW_I. Field for track t = `active[OB + t·(1+SELW_O) +: 1+SELW_O]`, LSB = enable, upper bits = select.
  - enable=0: the track's `_out` bit equals the same bit of its `_in`.
  - enable=1: the bit equals `clb_output[select]`, or 0 if select ≥ NCLB·CLBOUT.
- Carry chain:
  - `clb_cin[0 +: CARRY]` = `cin`
  - `clb_cin[k]` = `clb_cout[k-1]`
  - `cout` = `clb_cout[(NCLB-1)·CARRY +: CARRY]`
- Shadow register (CFG_BITS), when cen=1: shadow ← {shadow[CFG_BITS-2:0], shift_in}. `shift_out` = shadow[CFG_BITS-1].
- Bit counter `cnt`:
  - increments on each cen=1 cycle
  - saturates at CFG_BITS+1 (overshift)
- Commit, evaluated on set_in=1 against the pre-edge `cnt`:
  - `cnt` == CFG_BITS: active ← pre-edge shadow; `cnt` ← 0, or 1 if cen=1 in the same cycle.
  - any other `cnt`: active is unchanged, `cfg_err` ← 1, and `cnt` follows normal counting.
- `cfg_err` is cleared only by reset.
- Reset values: shadow=0, active=0, cnt=0, cfg_err=0, shift_out=0. With active=0, every CLB input = `single0_in[0]` and all tracks pass through.

## Timing
- All routing paths (trk→clb_input, clb_output→track out, carries) are combinational, with zero-cycle latency.
- A commit at edge N changes routing after edge N, i.e. from cycle N+1.
- `shift_out` presents shadow MSB. A bit entering on `shift_in` appears on `shift_out` CFG_BITS edges later.
- Simultaneous cen and set_in: the shift and commit both occur. The committed image is the pre-edge shadow.
- Asserting `rst` mid-shift or in the commit cycle clears all state immediately; a commit is not performed.

## Configuration
- `CB_CFG_SHADOW_EN` defined: double-buffered behaviour as above.
- `CB_CFG_SHADOW_EN` undefined:
  - routing decodes directly from the shadow, so it changes while shifting
  - set_in is ignored
  - `cnt` is removed
  - `cfg_err` is tied 0

## Test plan
- Reset with defaults, drive `single0_in`=4'b0001 → all 20 `clb_input` bits = 1, all `_out` = `_in`, `cfg_err`=0.
- Shift 220 bits, with CLB0 pin0 select=5 (`single1_in[1]`), then set_in=1 → next cycle `clb_input[0]` follows `single1_in[1]`. Before the commit it still follows `single0_in[0]`.
- Configure track 0 with enable=1, select=7 (CLB1 output 2), drive `clb_output`=10'h080 → `single0_out[0]`=1. With enable=0 it follows `single0_in[0]`.
- Shift 219 bits then set_in → no routing change, `cfg_err`=1. Shift 1 more bit and set_in → commit succeeds, `cfg_err` stays 1.
- Hold cen and set_in together at cnt=220 → commit of the pre-edge image, cnt=1 after the edge. Assert `rst` low mid-stream → outputs return to reset routing.
- Drive `cin`=1, `clb_cout`=2'b00 → `clb_cin`=2'b01, `cout`=0. Drive `clb_cout`=2'b10 → `cout`=1.
